sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single unified SRAM between the instruction-fetch port (IF) and the load/store unit (LSU) of the 5-stage pipeline.
- Serialises simultaneous requests, LSU first, then IF.
- Drives the SRAM handshake and generates the sram_stall input of the hazard detection unit, freezing the whole pipeline while any access is outstanding.
- Flags SRAM access timeouts.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- DATA_W, 32, data width on all ports.
- TIMEOUT, 255, maximum cycles sram_req may wait for sram_ack before the access is aborted (range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request, held stable while sram_stall=1
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid when if_ready=1
- if_ready  out  1  one-cycle pulse, fetch result available
- lsu_req  in  1  load/store request, held stable while sram_stall=1
- lsu_we  in  1  1=store, 0=load
- lsu_addr  in  ADDR_W  data address
- lsu_wdata  in  DATA_W  store data
- lsu_bmask  in  DATA_W/8  byte enables
- lsu_rdata  out  DATA_W  load data, valid when lsu_ready=1
- lsu_ready  out  1  one-cycle pulse, LSU access complete
- sram_req  out  1  SRAM access strobe
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_bmask  out  DATA_W/8  SRAM byte enables (all ones for IF reads)
- sram_rdata  in  DATA_W  SRAM read data, valid with sram_ack
- sram_ack  in  1  SRAM completion, one cycle
- sram_stall  out  1  to hazard unit: freeze PC and all pipeline registers
- timeout_err  out  1  sticky, set on any timeout, cleared only by rst

Behaviour:
- Reset (async, any state, including mid-access):
  - State goes to IDLE; pend_if and the wait counter clear.
  - All outputs are 0, including rdata registers and timeout_err. sram_req drops immediately.
  - An ack arriving after reset release is ignored.
- FSM states are IDLE, LSU_ACC, IF_ACC, DONE.
- IDLE:
  - lsu_req=1: register the LSU fields onto the sram_* outputs, set pend_if=if_req, go to LSU_ACC.
  - else if_req=1: register if_addr, sram_we=0, bmask all ones, go to IF_ACC.
  - else stay in IDLE.
- LSU_ACC / IF_ACC:
  - sram_req=1 with the address/data fields held constant for the whole state.
  - On sram_ack: capture sram_rdata into lsu_rdata or if_rdata (stores leave lsu_rdata unchanged). Drop sram_req on the next edge.
  - From LSU_ACC: go to IF_ACC if pend_if=1, else DONE. From IF_ACC: go to DONE.
  - Wait counter: cleared on state entry, increments each cycle without ack. Reaching TIMEOUT without ack sets timeout_err, drops sram_req, and forces that port's rdata to 0. The FSM then proceeds exactly as if acked.
- DONE:
  - Lasts one cycle. Pulse lsu_ready and/or if_ready for each port served in this transaction. Then go to IDLE.
  - Requests present during DONE are stale (the pipeline advances this cycle) and are ignored.
- sram_stall (combinational):
  - 1 in LSU_ACC and IF_ACC.
  - 1 in IDLE when if_req|lsu_req.
  - 0 in DONE, and in IDLE with no request.
- Latency with a zero-wait SRAM (ack in the first sram_req cycle): single port = 2 stall cycles, then the ready pulse. Both ports = 3 stall cycles, then both ready pulses together in DONE.
- Each additional SRAM wait cycle adds one stall cycle.
- sram_ack outside the ACC states is ignored.
- At most one access is outstanding; the IF access never starts before the LSU ack.

Test Plan:
- Reset, then lsu_req=1, lsu_we=0, lsu_addr=0x100, SRAM acks in the same cycle with 0xDEADBEEF. Required: sram_stall=1 for 2 cycles, sram_addr=0x100, then lsu_ready pulse with lsu_rdata=0xDEADBEEF, then stall=0.
- if_req and lsu_req (store 0x12345678 to 0x200, bmask 4'b0011) together, IF addr 0x40, ack 2 cycles after each sram_req. Required: LSU write issued first (sram_we=1, bmask 0011), then IF read (bmask 1111), stall for 7 cycles, both ready pulses in the same DONE cycle.
- if_req only, addr 0x0, ack after 3 wait cycles. Required: sram_req held 4 cycles with the address stable, if_ready one cycle, no lsu_ready.
- TIMEOUT=4, lsu_req with no ack. Required: sram_req high 4 cycles then low, timeout_err=1 and sticky, lsu_rdata=0, lsu_ready pulse, stall released.
- Assert rst for 1 cycle during LSU_ACC of a combined request. Required: sram_req=0 and sram_stall=0 immediately, state IDLE, no ready pulses, the late ack is ignored, and the next request is served normally.
- Requests held high through DONE. Required: no re-issue in DONE; a new access starts only from IDLE on the following cycle.

Source files
------------

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter_if
// Description : Fetch, load/store and SRAM-side signals of the SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_ready;

    logic                  lsu_req;
    logic                  lsu_we;
    logic [ADDR_W-1:0]     lsu_addr;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_bmask;
    logic [DATA_W-1:0]     lsu_rdata;
    logic                  lsu_ready;

    logic                  sram_req;
    logic                  sram_we;
    logic [ADDR_W-1:0]     sram_addr;
    logic [DATA_W-1:0]     sram_wdata;
    logic [DATA_W/8-1:0]   sram_bmask;
    logic [DATA_W-1:0]     sram_rdata;
    logic                  sram_ack;

    logic                  sram_stall;
    logic                  timeout_err;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_bmask,
               sram_rdata, sram_ack,
        output if_rdata, if_ready, lsu_rdata, lsu_ready,
               sram_req, sram_we, sram_addr, sram_wdata, sram_bmask,
               sram_stall, timeout_err
    );

    // Pipeline / SRAM side
    modport master (
        output if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_bmask,
               sram_rdata, sram_ack,
        input  if_rdata, if_ready, lsu_rdata, lsu_ready,
               sram_req, sram_we, sram_addr, sram_wdata, sram_bmask,
               sram_stall, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Serialises LSU and IF accesses onto one SRAM, LSU first, and
//               stalls the pipeline while an access is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  wire           clk,
    input  wire           rst,
    sram_arbiter_if.slave bus
);
    localparam int c_BM_W  = DATA_W / 8;
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LSU_ACC = 2'd1,
        IF_ACC  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_pend_if;
    logic                r_lsu_srv;
    logic                r_if_srv;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_req;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_BM_W-1:0]   r_bmask;
    logic [DATA_W-1:0]   r_lsu_rdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic                r_timeout_err;

    logic                w_in_acc;
    logic                w_timeout;
    logic                w_acc_end;
    logic                w_stall;
    logic                w_lsu_ready;
    logic                w_if_ready;

    assign w_in_acc  = (r_state == LSU_ACC) || (r_state == IF_ACC);
    // An ack in the last allowed cycle still wins over the timeout
    assign w_timeout = w_in_acc && !bus.sram_ack && (r_cnt == c_CNT_LAST);
    assign w_acc_end = w_in_acc && (bus.sram_ack || w_timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_lsu_ready = 1'b0;
        w_if_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = bus.lsu_req || bus.if_req;
                if (bus.lsu_req) begin
                    w_next = LSU_ACC;
                end else if (bus.if_req) begin
                    w_next = IF_ACC;
                end
            end
            LSU_ACC: begin
                w_stall = 1'b1;
                if (w_acc_end) begin
                    w_next = r_pend_if ? IF_ACC : DONE;
                end
            end
            IF_ACC: begin
                w_stall = 1'b1;
                if (w_acc_end) begin
                    w_next = DONE;
                end
            end
            default: begin
                // Requests seen here are stale: the pipeline advances this cycle
                w_lsu_ready = r_lsu_srv;
                w_if_ready  = r_if_srv;
                w_next      = IDLE;
            end
        endcase
        // Stall must vanish the moment reset is applied, even with requests held
        if (rst) begin
            w_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_if     <= 1'b0;
            r_lsu_srv     <= 1'b0;
            r_if_srv      <= 1'b0;
            r_cnt         <= '0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_bmask       <= '0;
            r_lsu_rdata   <= '0;
            r_if_rdata    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.lsu_req) begin
                        r_req     <= 1'b1;
                        r_we      <= bus.lsu_we;
                        r_addr    <= bus.lsu_addr;
                        r_wdata   <= bus.lsu_wdata;
                        r_bmask   <= bus.lsu_bmask;
                        r_pend_if <= bus.if_req;
                        r_lsu_srv <= 1'b1;
                        r_if_srv  <= 1'b0;
                        r_cnt     <= '0;
                    end else if (bus.if_req) begin
                        r_req     <= 1'b1;
                        r_we      <= 1'b0;
                        r_addr    <= bus.if_addr;
                        r_bmask   <= '1;
                        r_pend_if <= 1'b0;
                        r_lsu_srv <= 1'b0;
                        r_if_srv  <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                LSU_ACC: begin
                    if (bus.sram_ack) begin
                        if (!r_we) begin
                            r_lsu_rdata <= bus.sram_rdata;
                        end
                    end else if (w_timeout) begin
                        r_lsu_rdata   <= '0;
                        r_timeout_err <= 1'b1;
                    end
                    if (w_acc_end) begin
                        r_cnt <= '0;
                        // Chain straight into the pending fetch; its address is held stable
                        if (r_pend_if) begin
                            r_we     <= 1'b0;
                            r_addr   <= bus.if_addr;
                            r_bmask  <= '1;
                            r_if_srv <= 1'b1;
                        end else begin
                            r_req <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                IF_ACC: begin
                    if (bus.sram_ack) begin
                        r_if_rdata <= bus.sram_rdata;
                    end else if (w_timeout) begin
                        r_if_rdata    <= '0;
                        r_timeout_err <= 1'b1;
                    end
                    if (w_acc_end) begin
                        r_cnt <= '0;
                        r_req <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.sram_req    = r_req;
    assign bus.sram_we     = r_we;
    assign bus.sram_addr   = r_addr;
    assign bus.sram_wdata  = r_wdata;
    assign bus.sram_bmask  = r_bmask;
    assign bus.lsu_rdata   = r_lsu_rdata;
    assign bus.if_rdata    = r_if_rdata;
    assign bus.lsu_ready   = w_lsu_ready;
    assign bus.if_ready    = w_if_ready;
    assign bus.sram_stall  = w_stall;
    assign bus.timeout_err = r_timeout_err;
endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed self-checking bench for sram_arbiter (TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
    logic clk;
    logic rst;

    sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    int          n_stall, n_req, n_lsu_rdy, n_if_rdy, n_acc, n_addr_chg;
    logic [31:0] acc_addr [4];
    logic [31:0] acc_wd   [4];
    logic        acc_we   [4];
    logic [3:0]  acc_bm   [4];
    logic        prev_req, prev_ack;
    logic [31:0] prev_addr;
    int          ack_wait, wcnt;
    bit          no_ack;
    logic [31:0] rd_val;
    bit          rdy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        n_stall = 0; n_req = 0; n_lsu_rdy = 0; n_if_rdy = 0; n_acc = 0; n_addr_chg = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; wcnt = 0;
    endtask

    task automatic monitor();
        if (bus.sram_stall) n_stall++;
        if (bus.sram_req) begin
            n_req++;
            if (!prev_req || prev_ack) begin
                if (n_acc < 4) begin
                    acc_addr[n_acc] = bus.sram_addr;
                    acc_wd[n_acc]   = bus.sram_wdata;
                    acc_we[n_acc]   = bus.sram_we;
                    acc_bm[n_acc]   = bus.sram_bmask;
                end
                n_acc++;
            end else if (bus.sram_addr !== prev_addr) begin
                n_addr_chg++;
            end
        end
        if (bus.lsu_ready) n_lsu_rdy++;
        if (bus.if_ready)  n_if_rdy++;
        prev_req  = bus.sram_req;
        prev_ack  = bus.sram_ack;
        prev_addr = bus.sram_addr;
    endtask

    // One clock; the SRAM model answers after ack_wait wait cycles
    task automatic step();
        @(posedge clk);
        #1;
        bus.sram_ack = 1'b0;
        if (bus.sram_req && !no_ack) begin
            if (wcnt == ack_wait) begin
                bus.sram_ack   = 1'b1;
                bus.sram_rdata = rd_val;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end
        #1;
        monitor();
    endtask

    // Runs from the request cycle up to the cycle with a ready pulse
    task automatic run_txn(input string tag, output bit got);
        got = 1'b0;
        #1;
        monitor();
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (bus.lsu_ready || bus.if_ready) got = 1'b1;
        end
        check({tag, " ready seen"}, 64'(got), 64'd1);
    endtask

    task automatic end_txn(input string tag);
        bus.lsu_req = 1'b0;
        bus.if_req  = 1'b0;
        step();
        check({tag, " after done"}, {bus.sram_stall, bus.sram_req, bus.lsu_ready, bus.if_ready}, 4'b0000);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_addr = '0;
        bus.lsu_wdata = '0; bus.lsu_bmask = '0;
        bus.sram_ack = 1'b0; bus.sram_rdata = '0;
        ack_wait = 0; no_ack = 1'b0; rd_val = '0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        check("rst outputs", {bus.sram_req, bus.sram_we, bus.sram_stall, bus.lsu_ready,
                              bus.if_ready, bus.timeout_err}, 6'd0);
        check("rst addr/bmask", {bus.sram_addr, bus.sram_bmask}, 36'd0);
        check("rst rdata", {bus.lsu_rdata, bus.if_rdata}, 64'd0);
        rst = 1'b0;
        #1;

        // Single LSU load, zero-wait SRAM
        clear_mon(); ack_wait = 0; rd_val = 32'hDEADBEEF;
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h100; bus.lsu_bmask = 4'hF;
        run_txn("t1", rdy);
        check("t1 ready pair", {bus.lsu_ready, bus.if_ready}, 2'b10);
        check("t1 lsu_rdata", bus.lsu_rdata, 32'hDEADBEEF);
        end_txn("t1");
        check("t1 stall cycles", n_stall, 2);
        check("t1 sram_addr", acc_addr[0], 32'h100);
        check("t1 lsu pulses", n_lsu_rdy, 1);

        // LSU store + IF fetch together, two wait cycles each
        clear_mon(); ack_wait = 2; rd_val = 32'hCAFEF00D;
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'h200;
        bus.lsu_wdata = 32'h12345678; bus.lsu_bmask = 4'b0011;
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        run_txn("t2", rdy);
        check("t2 both ready", {bus.lsu_ready, bus.if_ready}, 2'b11);
        check("t2 if_rdata", bus.if_rdata, 32'hCAFEF00D);
        check("t2 lsu_rdata kept", bus.lsu_rdata, 32'hDEADBEEF);
        end_txn("t2");
        check("t2 stall cycles", n_stall, 7);
        check("t2 accesses", n_acc, 2);
        check("t2 first access", {acc_we[0], acc_bm[0], acc_addr[0], acc_wd[0]},
              {1'b1, 4'b0011, 32'h200, 32'h12345678});
        check("t2 second access", {acc_we[1], acc_bm[1], acc_addr[1]}, {1'b0, 4'b1111, 32'h40});
        check("t2 req cycles", n_req, 6);

        // IF only, three wait cycles (ack lands in the last allowed cycle)
        clear_mon(); ack_wait = 3; rd_val = 32'h0BADC0DE;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        run_txn("t3", rdy);
        check("t3 ready pair", {bus.lsu_ready, bus.if_ready}, 2'b01);
        check("t3 if_rdata", bus.if_rdata, 32'h0BADC0DE);
        end_txn("t3");
        check("t3 req cycles", n_req, 4);
        check("t3 addr stable", n_addr_chg, 0);
        check("t3 access", {acc_bm[0], acc_addr[0]}, {4'hF, 32'h0});
        check("t3 pulses", {n_if_rdy[3:0], n_lsu_rdy[3:0]}, 8'h10);
        check("t3 no timeout", bus.timeout_err, 1'b0);

        // LSU load with no ack: times out after 4 request cycles
        clear_mon(); no_ack = 1'b1;
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h300; bus.lsu_bmask = 4'hF;
        run_txn("t4", rdy);
        check("t4 done state", {bus.lsu_ready, bus.sram_req, bus.timeout_err}, 3'b101);
        check("t4 lsu_rdata", bus.lsu_rdata, 32'h0);
        end_txn("t4");
        check("t4 req cycles", n_req, 4);
        check("t4 stall cycles", n_stall, 5);
        no_ack = 1'b0;

        // Requests held through DONE: no re-issue until IDLE
        clear_mon(); ack_wait = 0; rd_val = 32'h13579BDF;
        bus.if_req = 1'b1; bus.if_addr = 32'h80;
        run_txn("t6", rdy);
        check("t6 done no req", {bus.sram_req, bus.if_ready}, 2'b01);
        step();
        check("t6 idle", {bus.sram_req, bus.sram_stall}, 2'b01);
        step();
        check("t6 reissue", {bus.sram_req, bus.sram_addr}, {1'b1, 32'h80});
        step();
        check("t6 second ready", bus.if_ready, 1'b1);
        end_txn("t6");
        check("t6 sticky err", bus.timeout_err, 1'b1);

        // Reset during LSU_ACC of a combined request
        clear_mon(); no_ack = 1'b1;
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h500;
        bus.if_req = 1'b1; bus.if_addr = 32'h600;
        #1;
        monitor();
        step();
        check("t5 in access", bus.sram_req, 1'b1);
        step();
        rst = 1'b1;
        bus.lsu_req = 1'b0; bus.if_req = 1'b0;
        #1;
        check("t5 rst immediate", {bus.sram_req, bus.sram_stall, bus.lsu_ready, bus.if_ready,
                                   bus.timeout_err}, 5'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; no_ack = 1'b0;
        bus.sram_ack = 1'b1; bus.sram_rdata = 32'hFFFFFFFF;
        clear_mon();
        step();
        check("t5 late ack ignored", {bus.sram_req, bus.sram_stall, bus.lsu_ready, bus.if_ready}, 4'd0);
        check("t5 rdata cleared", {bus.lsu_rdata, bus.if_rdata}, 64'd0);
        step();
        check("t5 still idle", {bus.sram_req, n_lsu_rdy[3:0], n_if_rdy[3:0]}, 9'd0);
        clear_mon(); ack_wait = 0; rd_val = 32'h55AA55AA;
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h700;
        run_txn("t5b", rdy);
        check("t5b lsu_rdata", bus.lsu_rdata, 32'h55AA55AA);
        end_txn("t5b");
        check("t5b stall cycles", n_stall, 2);
        check("t5b pulses", {n_lsu_rdy[3:0], n_if_rdy[3:0]}, 8'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
